// File: rtl/pmod.sv
// pmod: QPSK modulator with a frame-synchronous 15-bit LFSR scrambler.
// Scrambled bits pair up as I/Q, map to +/-AMP and carry frame sof/eof markers.
module pmod #(
  parameter int unsigned        FRAME_SYMS = 1024,
  parameter logic signed [11:0] AMP        = 12'sd724,
  parameter logic [14:0]        SCR_SEED   = 15'h7FFF
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               di,
  input  logic               di_vld,
  input  logic               di_sof,
  output logic signed [11:0] do_re,
  output logic signed [11:0] do_im,
  output logic               do_vld,
  output logic               do_sof,
  output logic               do_eof,
  output logic               err
);
  localparam int unsigned      CNT_W    = 16;
  localparam logic [CNT_W-1:0] LAST_SYM = CNT_W'(FRAME_SYMS - 1);

  typedef enum logic {S_IDLE, S_RUN} state_t;

  state_t           r_state;
  state_t           w_state_nxt;
  logic [14:0]      r_s;
  logic             r_have_i;
  logic             r_i_bit;
  logic [CNT_W-1:0] r_cnt;

  logic             w_restart;
  logic             w_accept;
  logic [14:0]      w_s_cur;
  logic             w_p;
  logic             w_b;
  logic             w_emit;
  logic             w_last;
  logic             w_err;

  function automatic logic signed [11:0] f_map(input logic b);
    return b ? -AMP : AMP;
  endfunction

  // State register
  always_ff @(posedge clk) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_state_nxt;
  end

  // Next-state logic; an eof symbol drops back to IDLE, a sof restarts in place
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:  if (w_restart) w_state_nxt = S_RUN;
      S_RUN:   if (w_emit && w_last) w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // Input qualification, scrambler tap and protocol-error detection
  always_comb begin
    w_restart = di_vld && di_sof;
    w_accept  = di_vld && (di_sof || (r_state == S_RUN));
    w_s_cur   = w_restart ? SCR_SEED : r_s;
    w_p       = w_s_cur[14] ^ w_s_cur[13];
    w_b       = di ^ w_p;
    w_emit    = w_accept && !di_sof && r_have_i;
    w_last    = (r_cnt == LAST_SYM);
    // a bit arriving right after the eof symbol, with no new sof, is a violation
    w_err     = (w_restart && (r_state == S_RUN)) ||
                (di_vld && !di_sof && (r_state == S_IDLE) && do_vld && do_eof);
  end

  // Datapath: LFSR, I-bit holding register, symbol counter and output registers
  always_ff @(posedge clk) begin
    if (rst) begin
      r_s      <= SCR_SEED;
      r_have_i <= 1'b0;
      r_i_bit  <= 1'b0;
      r_cnt    <= '0;
      do_re    <= '0;
      do_im    <= '0;
      do_vld   <= 1'b0;
      do_sof   <= 1'b0;
      do_eof   <= 1'b0;
      err      <= 1'b0;
    end else begin
      do_vld <= w_emit;
      do_sof <= w_emit && (r_cnt == '0);
      do_eof <= w_emit && w_last;
      err    <= w_err;
      if (w_accept) r_s <= {w_s_cur[13:0], w_p};
      if (w_restart) begin
        r_have_i <= 1'b1;
        r_i_bit  <= w_b;
        r_cnt    <= '0;
      end else if (w_accept) begin
        if (r_have_i) begin
          do_re    <= f_map(r_i_bit);
          do_im    <= f_map(w_b);
          r_have_i <= 1'b0;
          r_cnt    <= w_last ? '0 : r_cnt + CNT_W'(1);
        end else begin
          r_have_i <= 1'b1;
          r_i_bit  <= w_b;
        end
      end
    end
  end
endmodule

// File: tb/tb_pmod.sv
// tb_pmod: table vectors, directed frame sequences and random traffic for pmod,
// each cycle compared against a frame-level reference model.
module tb_pmod;
  localparam int unsigned        FS   = 8;
  localparam logic signed [11:0] AMP  = 12'sd724;
  localparam logic [14:0]        SEED = 15'h7FFF;

  logic clk = 1'b0;
  logic rst, di, di_vld, di_sof;
  logic signed [11:0] do_re, do_im;
  logic do_vld, do_sof, do_eof, err;

  pmod #(.FRAME_SYMS(FS), .AMP(AMP), .SCR_SEED(SEED)) dut (
    .clk(clk), .rst(rst), .di(di), .di_vld(di_vld), .di_sof(di_sof),
    .do_re(do_re), .do_im(do_im), .do_vld(do_vld), .do_sof(do_sof),
    .do_eof(do_eof), .err(err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic v, s, d;
    logic ev, es, ee, er;
    logic signed [11:0] ere, eim;
  } vec_t;

  vec_t tbl[18];
  int   n_cmp = 0;
  int   n_bad = 0;
  int   n_err_obs = 0;

  // reference model: scrambler sequence indexed by bit position within a frame
  bit   pseq[2*FS];
  bit   m_act = 1'b0;
  bit   m_ibit = 1'b0;
  bit   m_eof_prev = 1'b0;
  int   m_k = 0;
  logic e_vld, e_sof, e_eof, e_err;
  logic signed [11:0] e_re = '0;
  logic signed [11:0] e_im = '0;

  bit          cap_on = 1'b0;
  logic [25:0] cap[$];

  task automatic check(input string name, input logic [27:0] act, input logic [27:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s @%0t: got vld,sof,eof,err,re,im=%h want %h", name, $time, act, exp);
    end
  endtask

  task automatic model(input bit r, input bit v, input bit s, input bit d);
    bit b;
    int idx;
    e_vld = 1'b0; e_sof = 1'b0; e_eof = 1'b0; e_err = 1'b0;
    if (r) begin
      m_act = 1'b0; m_k = 0; e_re = '0; e_im = '0;
    end else if (v && s) begin
      e_err  = m_act;
      m_act  = 1'b1;
      m_ibit = d ^ pseq[0];
      m_k    = 1;
    end else if (v && m_act) begin
      b = d ^ pseq[m_k];
      if (m_k % 2 == 0) begin
        m_ibit = b;
      end else begin
        idx   = m_k / 2;
        e_vld = 1'b1;
        e_re  = m_ibit ? -AMP : AMP;
        e_im  = b ? -AMP : AMP;
        e_sof = (idx == 0);
        e_eof = (idx == int'(FS) - 1);
        if (e_eof) m_act = 1'b0;
      end
      m_k++;
    end else if (v) begin
      e_err = m_eof_prev;
    end
    m_eof_prev = e_eof;
  endtask

  task automatic step(input bit r, input bit v, input bit s, input bit d, input string name);
    rst = r; di_vld = v; di_sof = s; di = d;
    model(r, v, s, d);
    @(posedge clk);
    #1;
    if (err) n_err_obs++;
    if (cap_on && do_vld) cap.push_back({do_sof, do_eof, do_re, do_im});
    check(name, {do_vld, do_sof, do_eof, err, do_re, do_im},
          {e_vld, e_sof, e_eof, e_err, e_re, e_im});
  endtask

  task automatic send_bits(input bit bits[$], input int gap_pct, input string name);
    foreach (bits[i]) begin
      while (gap_pct > 0 && int'($urandom_range(99)) < gap_pct)
        step(1'b0, 1'b0, 1'($urandom_range(1)), 1'($urandom_range(1)), name);
      step(1'b0, 1'b1, (i == 0), bits[i], name);
    end
  endtask

  function automatic void rand_bits(output bit q[$], input int n);
    q = {};
    for (int i = 0; i < n; i++) q.push_back(1'($urandom_range(1)));
  endfunction

  initial begin
    logic [14:0] s;
    bit q[$];
    bit q2[$];
    logic [25:0] cap_a[$];

    s = SEED;
    for (int k = 0; k < 2 * int'(FS); k++) begin
      pseq[k] = s[14] ^ s[13];
      s = {s[13:0], pseq[k]};
    end

    // all-zero frame from seed 7FFF: p is 0 for bits 0..13, 1 at bit 14, 0 at bit 15
    for (int i = 0; i < 16; i++)
      tbl[i] = '{v: 1'b1, s: (i == 0), d: 1'b0, ev: (i % 2 == 1), es: (i == 1),
                 ee: (i == 15), er: 1'b0,
                 ere: (i == 0) ? 12'sd0 : ((i == 15) ? -AMP : AMP),
                 eim: (i == 0) ? 12'sd0 : AMP};
    tbl[16] = '{v: 1'b1, s: 1'b0, d: 1'b0, ev: 1'b0, es: 1'b0, ee: 1'b0, er: 1'b1,
                ere: -AMP, eim: AMP};
    tbl[17] = '{v: 1'b1, s: 1'b0, d: 1'b1, ev: 1'b0, es: 1'b0, ee: 1'b0, er: 1'b0,
                ere: -AMP, eim: AMP};

    step(1'b1, 1'b1, 1'b1, 1'b1, "reset");
    step(1'b1, 1'b0, 1'b0, 1'b0, "reset");
    step(1'b0, 1'b0, 1'b0, 1'b0, "idle");
    step(1'b0, 1'b1, 1'b0, 1'b1, "idle_nosof");
    step(1'b0, 1'b0, 1'b0, 1'b0, "idle");

    for (int i = 0; i < 18; i++) begin
      step(1'b0, tbl[i].v, tbl[i].s, tbl[i].d, "tbl_model");
      check($sformatf("tbl[%0d]", i), {do_vld, do_sof, do_eof, err, do_re, do_im},
            {tbl[i].ev, tbl[i].es, tbl[i].ee, tbl[i].er, tbl[i].ere, tbl[i].eim});
    end

    // fixed 8-bit pattern at the head of a frame
    q = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0};
    rand_bits(q2, 8);
    q = {q, q2};
    send_bits(q, 0, "pattern");
    step(1'b0, 1'b0, 1'b0, 1'b0, "idle");

    // same data continuous and with 50% gaps must give identical symbols
    rand_bits(q, 16);
    cap.delete(); cap_on = 1'b1;
    send_bits(q, 0, "cont");
    step(1'b0, 1'b0, 1'b0, 1'b0, "idle");
    cap_a = cap;
    cap.delete();
    send_bits(q, 50, "gapped");
    step(1'b0, 1'b0, 1'b0, 1'b0, "idle");
    cap_on = 1'b0;
    check("gap_count", 28'(cap.size()), 28'(cap_a.size()));
    for (int i = 0; i < cap_a.size() && i < cap.size(); i++)
      check($sformatf("gap_sym[%0d]", i), 28'(cap[i]), 28'(cap_a[i]));

    // sof again at bit 5: one err, pending I dropped, fresh frame follows
    n_err_obs = 0;
    rand_bits(q, 5);
    send_bits(q, 0, "restart_b5");
    rand_bits(q, 16);
    send_bits(q, 0, "restart_b5");
    step(1'b0, 1'b0, 1'b0, 1'b0, "idle");
    check("restart_err_once", 28'(n_err_obs), 28'(1));

    // sof coinciding with the last symbol's Q bit: restart, no eof
    n_err_obs = 0;
    rand_bits(q, 15);
    send_bits(q, 0, "restart_last");
    rand_bits(q, 16);
    send_bits(q, 0, "restart_last");
    step(1'b0, 1'b0, 1'b0, 1'b0, "idle");
    check("restart_last_err_once", 28'(n_err_obs), 28'(1));

    // reset after 3 symbols, then a new frame from the seed
    rand_bits(q, 6);
    send_bits(q, 0, "pre_rst");
    step(1'b1, 1'b1, 1'b0, 1'b1, "mid_rst");
    step(1'b1, 1'b1, 1'b1, 1'b0, "mid_rst");
    step(1'b0, 1'b0, 1'b0, 1'b0, "post_rst");
    step(1'b0, 1'b1, 1'b0, 1'b1, "post_rst");
    rand_bits(q, 16);
    send_bits(q, 0, "post_rst_frame");

    // random traffic with occasional restarts and resets
    for (int c = 0; c < 3000; c++) begin
      bit r, v, sf;
      r  = ($urandom_range(199) == 0);
      v  = 1'($urandom_range(1));
      sf = m_act ? ($urandom_range(99) < 3) : ($urandom_range(99) < 30);
      step(r, v, sf, 1'($urandom_range(1)), "random");
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
